// File: rtl/data_memory_unit_if.sv
// data_memory_unit_if: request/response bus between the ALU stage and the data memory unit
interface data_memory_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy
  );
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, busy
  );
endinterface

// File: rtl/data_memory_unit.sv
// data_memory_unit: fixed-latency RISC-V load/store stage with lane select, extension and error flagging
module data_memory_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic               clk,
  input logic               reset,
  data_memory_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          error_q;
  logic [31:0]   mem [DEPTH_WORDS];
  logic          accept, commit, legal, misaligned, err, unused_addr;
  logic [AW-1:0] idx;
  logic [31:0]   word, wrep, ld;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic [3:0]    wmask;
  assign unused_addr = ^bus.req_addr[31:AW+2];
  assign accept = state_q == IDLE && bus.req_valid;
  assign commit = state_q == WAIT && cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = WAIT;
        cnt_d   = CW'(LATENCY - 1);
      end
      WAIT: begin
        state_d = cnt_q == '0 ? RESP : WAIT;
        cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    idx        = addr_q[AW+1:2];
    word       = mem[idx];
    legal      = write_q ? f3_q inside {3'b000, 3'b001, 3'b010}
                         : f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misaligned = (f3_q[1:0] == 2'b01 && addr_q[0]) || (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
    err        = !legal || misaligned;
    lb         = word[{addr_q[1:0], 3'b000} +: 8];
    lh         = addr_q[1] ? word[31:16] : word[15:0];
    ld         = f3_q == 3'b000 ? {{24{lb[7]}}, lb} :
                 f3_q == 3'b100 ? {24'h0, lb} :
                 f3_q == 3'b001 ? {{16{lh[15]}}, lh} :
                 f3_q == 3'b101 ? {16'h0, lh} : word;
    wmask      = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                 f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wrep       = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                 f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        rdata_q <= (err || write_q) ? 32'h0 : ld;
        error_q <= err;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= bus.req_write;
      f3_q    <= bus.req_funct3;
      addr_q  <= bus.req_addr[AW+1:0];
      wdata_q <= bus.req_wdata;
    end
  end
  // the array is deliberately outside reset; an aborted commit must not write
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (commit && !reset && write_q && !err && wmask[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.busy      = state_q != IDLE;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = error_q;
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: directed and random load/store traffic against a byte-array model, LATENCY 2 and 1
module tb_data_memory_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  vld = 2'b00;
  logic        wr = 1'b0;
  logic [2:0]  f3 = 3'b0;
  logic [31:0] addr = 32'h0, wd = 32'h0;
  int          sel = 0;
  int          n_checks = 0, n_fail = 0;
  logic [7:0]  mb [2][1024];
  logic        o_ready, o_valid, o_error, o_busy;
  logic [31:0] o_rdata;
  always #5 clk = ~clk;
  data_memory_unit_if b0();
  data_memory_unit_if b1();
  assign b0.req_valid = vld[0];
  assign b0.req_write = wr;
  assign b0.req_funct3 = f3;
  assign b0.req_addr = addr;
  assign b0.req_wdata = wd;
  assign b1.req_valid = vld[1];
  assign b1.req_write = wr;
  assign b1.req_funct3 = f3;
  assign b1.req_addr = addr;
  assign b1.req_wdata = wd;
  data_memory_unit #(.DEPTH_WORDS(256), .LATENCY(2)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  data_memory_unit #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  assign o_ready = sel == 1 ? b1.req_ready : b0.req_ready;
  assign o_valid = sel == 1 ? b1.rsp_valid : b0.rsp_valid;
  assign o_error = sel == 1 ? b1.rsp_error : b0.rsp_error;
  assign o_busy  = sel == 1 ? b1.busy : b0.busy;
  assign o_rdata = sel == 1 ? b1.rsp_rdata : b0.rsp_rdata;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d): got %h expected %h", tag, sel, got, exp);
    end
  endtask
  // memory seen as 1024 bytes; addresses wrap modulo the array size
  task automatic model(input int s, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] r, output logic e);
    int size, ba;
    logic [31:0] v;
    bit legal;
    size  = f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : f[1:0] == 2'b10 ? 4 : 1;
    legal = w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
    ba    = int'(a[9:0]);
    e     = !legal || (ba % size != 0);
    r     = 32'h0;
    if (!e) begin
      if (w) for (int i = 0; i < size; i++) mb[s][ba+i] = d[8*i +: 8];
      else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v |= 32'(mb[s][ba+i]) << (8 * i);
        if (!f[2] && size < 4 && v[8*size-1]) v |= 32'hFFFFFFFF << (8 * size);
        r = v;
      end
    end
  endtask
  task automatic do_req(input int s, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] r, output logic e);
    logic [31:0] er;
    logic ee;
    int k, l;
    l = s == 1 ? 1 : 2;
    sel = s;
    @(negedge clk);
    wr = w; f3 = f; addr = a; wd = d; vld[s] = 1'b1;
    k = 0;
    while (!o_ready && k < 20) begin @(negedge clk); k++; end
    check("ready_before", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1 vld[s] = 1'b0;
    model(s, w, f, a, d, er, ee);
    check("ready_in_wait", 32'(o_ready), 32'd0);
    k = 0;
    while (!o_valid && k < l + 4) begin
      @(posedge clk);
      #1 k++;
      wr = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wd = $urandom; vld[s] = 1'($urandom);
    end
    vld[s] = 1'b0;
    check("latency", 32'(k), 32'(l));
    check("rdata", o_rdata, er);
    check("error", 32'(o_error), 32'(ee));
    r = o_rdata;
    e = o_error;
    @(posedge clk);
    #1 check("pulse_one_cycle", 32'(o_valid), 32'd0);
    check("back_idle", 32'(o_ready), 32'd1);
  endtask
  initial begin
    logic [31:0] r;
    logic e;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0 check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_rdata", o_rdata, 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
    end
    for (int s = 0; s < 2; s++) begin
      do_req(s, 1, 3'b010, 32'h10, 32'h8BADF00D, r, e);
      check("sw_err", 32'(e), 32'd0);
      do_req(s, 0, 3'b010, 32'h10, 32'h0, r, e);
      check("lw", r, 32'h8BADF00D);
      do_req(s, 0, 3'b000, 32'h13, 32'h0, r, e);
      check("lb", r, 32'hFFFFFF8B);
      do_req(s, 0, 3'b100, 32'h13, 32'h0, r, e);
      check("lbu", r, 32'h0000008B);
      do_req(s, 0, 3'b001, 32'h12, 32'h0, r, e);
      check("lh", r, 32'hFFFF8BAD);
      do_req(s, 0, 3'b101, 32'h10, 32'h0, r, e);
      check("lhu", r, 32'h0000F00D);
      do_req(s, 1, 3'b000, 32'h11, 32'h5A, r, e);
      do_req(s, 0, 3'b010, 32'h10, 32'h0, r, e);
      check("sb_merge", r, 32'h8BAD5A0D);
      do_req(s, 1, 3'b010, 32'h400, 32'hCAFEBABE, r, e);
      do_req(s, 0, 3'b010, 32'h0, 32'h0, r, e);
      check("wrap", r, 32'hCAFEBABE);
      do_req(s, 1, 3'b001, 32'h11, 32'hFFFF, r, e);
      check("sh_mis_err", 32'(e), 32'd1);
      check("sh_mis_rdata", r, 32'd0);
      do_req(s, 1, 3'b010, 32'h12, 32'hFFFFFFFF, r, e);
      check("sw_mis_err", 32'(e), 32'd1);
      do_req(s, 0, 3'b011, 32'h10, 32'h0, r, e);
      check("ld_f3_011_err", 32'(e), 32'd1);
      check("ld_f3_011_rdata", r, 32'd0);
      do_req(s, 0, 3'b010, 32'h10, 32'h0, r, e);
      check("after_err", r, 32'h8BAD5A0D);
      do_req(s, 1, 3'b010, 32'h20, 32'h0, r, e);
      @(negedge clk);
      wr = 1'b1; f3 = 3'b010; addr = 32'h20; wd = 32'h12345678; vld[s] = 1'b1;
      @(posedge clk);
      #1 vld[s] = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("abort_busy", 32'(o_busy), 32'd0);
      check("abort_ready", 32'(o_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
        check("abort_no_rsp", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1;
      end
      do_req(s, 0, 3'b010, 32'h20, 32'h0, r, e);
      check("abort_no_write", r, 32'h0);
      @(negedge clk);
      reset = 1'b1; vld[s] = 1'b1; wr = 1'b0; f3 = 3'b010; addr = 32'h10;
      @(posedge clk);
      #1 reset = 1'b0;
      vld[s] = 1'b0;
      check("rst_valid_not_taken", 32'(o_busy), 32'd0);
      @(posedge clk);
      #1 check("rst_valid_still_idle", 32'(o_busy), 32'd0);
    end
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 256; w++) do_req(s, 1, 3'b010, 32'(w * 4), $urandom, r, e);
      for (int n = 0; n < 200; n++)
        do_req(s, 1'($urandom), 3'($urandom), $urandom, $urandom, r, e);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
